// File: rtl/vga_dac_sequencer.sv
// vga_dac_sequencer: VGA raster timing, 4-deep RGB pixel FIFO, blanked DAC codes
// and frame-synchronous DAC bias selection.
module vga_dac_sequencer #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int BIAS_RST    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    input  logic       cfg_wr,
    input  logic [2:0] cfg_bias_r,
    input  logic [2:0] cfg_bias_gb,
    input  logic       underflow_clr,
    output logic [7:0] dac_r,
    output logic [7:0] dac_g,
    output logic [7:0] dac_b,
    output logic [2:0] bias_r,
    output logic [2:0] bias_gb,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic SA = 1'(SYNC_ACTIVE);
    localparam logic [2:0] BR = 3'(BIAS_RST);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [23:0]   mem [4];
    logic [23:0]   head;
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic [2:0]    shadow_r, shadow_gb;
    logic          h_last, v_last, active, hs_on, vs_on, full, empty, push, pop, bias_load;

    always_comb begin
        h_last    = h_cnt == HW'(H_TOTAL - 1);
        v_last    = v_cnt == VW'(V_TOTAL - 1);
        active    = en && h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
        hs_on     = en && h_cnt >= HW'(H_ACTIVE + H_FP) && h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC);
        vs_on     = en && v_cnt >= VW'(V_ACTIVE + V_FP) && v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC);
        full      = count == 3'd4;
        empty     = count == 3'd0;
        push      = pix_valid && !full;
        pop       = active && !empty;
        bias_load = en && h_cnt == '0 && v_cnt == VW'(V_ACTIVE);
        head      = mem[rd_ptr];
    end

    assign pix_ready = !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last)
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {pix_r, pix_g, pix_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + {1'b0, push};
            rd_ptr <= rd_ptr + {1'b0, pop};
            count  <= count + {2'b0, push} - {2'b0, pop};
        end
    end

    // Bias is latched from the shadow at the top of vertical blanking; a write
    // landing in that same cycle only reaches the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_r       <= '0;
            dac_g       <= '0;
            dac_b       <= '0;
            hsync       <= ~SA;
            vsync       <= ~SA;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            bias_r      <= BR;
            bias_gb     <= BR;
            shadow_r    <= BR;
            shadow_gb   <= BR;
        end else begin
            dac_r       <= pop ? head[23:16] : 8'd0;
            dac_g       <= pop ? head[15:8]  : 8'd0;
            dac_b       <= pop ? head[7:0]   : 8'd0;
            hsync       <= hs_on ? SA : ~SA;
            vsync       <= vs_on ? SA : ~SA;
            frame_start <= en && h_cnt == '0 && v_cnt == '0;
            underflow   <= (active && empty) || (underflow && !underflow_clr);
            if (bias_load) begin
                bias_r  <= shadow_r;
                bias_gb <= shadow_gb;
            end
            if (cfg_wr) begin
                shadow_r  <= cfg_bias_r;
                shadow_gb <= cfg_bias_gb;
            end
        end
    end
endmodule

// File: tb/tb_vga_dac_sequencer.sv
// tb_vga_dac_sequencer: directed and randomized checks of the VGA DAC sequencer
// against a raster-position / pixel-queue reference model, using a reduced raster.
module tb_vga_dac_sequencer;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic SAL = 1'b0;
    localparam logic [2:0] BR = 3'd4;

    logic       clk, rst, en, pix_valid, pix_ready, cfg_wr, underflow_clr;
    logic [7:0] pix_r, pix_g, pix_b, dac_r, dac_g, dac_b;
    logic [2:0] cfg_bias_r, cfg_bias_gb, bias_r, bias_gb;
    logic       hsync, vsync, frame_start, underflow;

    vga_dac_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(0), .BIAS_RST(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .cfg_wr(cfg_wr),
        .cfg_bias_r(cfg_bias_r), .cfg_bias_gb(cfg_bias_gb), .underflow_clr(underflow_clr),
        .dac_r(dac_r), .dac_g(dac_g), .dac_b(dac_b), .bias_r(bias_r), .bias_gb(bias_gb),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0, errors = 0, pops = 0, t = 0;
    logic [23:0] q[$];
    logic [23:0] e_dac;
    logic [2:0]  sh_r, sh_gb, e_br, e_bgb;
    logic        e_hs, e_vs, e_fs, e_uf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        t = 0;
        sh_r = BR; sh_gb = BR; e_br = BR; e_bgb = BR;
        e_hs = ~SAL; e_vs = ~SAL; e_fs = 1'b0; e_uf = 1'b0; e_dac = '0;
    endtask

    task automatic chk_outs();
        chk("dac", {dac_r, dac_g, dac_b}, e_dac);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("frame_start", frame_start, e_fs);
        chk("underflow", underflow, e_uf);
        chk("bias", {bias_r, bias_gb}, {e_br, e_bgb});
    endtask

    // Model: t is the linear raster position; h/v are derived arithmetically.
    task automatic cyc();
        int h, v;
        bit act, emp, psh;
        h = t % HT;
        v = t / HT;
        act = en && h < HA && v < VA;
        emp = q.size() == 0;
        chk("pix_ready", pix_ready, q.size() < 4);
        psh = pix_valid && q.size() < 4;
        if (act && !emp) begin
            e_dac = q.pop_front();
            pops++;
        end else
            e_dac = '0;
        e_uf = (act && emp) || (e_uf && !underflow_clr);
        e_hs = (en && h >= HA + HF && h < HA + HF + HS) ? SAL : ~SAL;
        e_vs = (en && v >= VA + VF && v < VA + VF + VS) ? SAL : ~SAL;
        e_fs = en && t == 0;
        if (en && t == VA * HT) begin
            e_br = sh_r;
            e_bgb = sh_gb;
        end
        if (cfg_wr) begin
            sh_r = cfg_bias_r;
            sh_gb = cfg_bias_gb;
        end
        if (psh) q.push_back({pix_r, pix_g, pix_b});
        t = en ? (t + 1) % FT : 0;
        @(posedge clk);
        #1;
        chk_outs();
    endtask

    task automatic run(input int n, input int pv_pct, input bit rnd);
        for (int i = 0; i < n; i++) begin
            pix_valid = $urandom_range(99) < pv_pct;
            {pix_r, pix_g, pix_b} = 24'($urandom);
            cfg_wr = rnd && $urandom_range(29) == 0;
            {cfg_bias_r, cfg_bias_gb} = 6'($urandom);
            underflow_clr = rnd && $urandom_range(9) == 0;
            cyc();
        end
        cfg_wr = 1'b0;
        underflow_clr = 1'b0;
    endtask

    task automatic run_to(input int target, input int pv_pct);
        for (int i = 0; i < FT && t != target; i++) run(1, pv_pct, 1'b0);
        chk("run_to", t, target);
    endtask

    initial begin
        int hl, vl;
        rst = 1'b1; en = 1'b0; pix_valid = 1'b0; cfg_wr = 1'b0; underflow_clr = 1'b0;
        pix_r = '0; pix_g = '0; pix_b = '0; cfg_bias_r = '0; cfg_bias_gb = '0;
        model_reset();
        #12;
        chk_outs();
        chk("pix_ready_rst", pix_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Empty frame: sync widths, blank DACs, underflow raised
        en = 1'b1;
        hl = 0; vl = 0;
        for (int i = 0; i < FT; i++) begin
            cyc();
            hl += (hsync == 1'b0);
            vl += (vsync == 1'b0);
        end
        chk("hsync_low_cycles", hl, HS * VT);
        chk("vsync_low_cycles", vl, VS * HT);
        chk("underflow_set", underflow, 1'b1);

        // Preload 4 pixels while disabled, then release the raster
        en = 1'b0;
        cyc(); cyc();
        pix_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix_r = 8'(8'h11 + 8'h33 * i);
            pix_g = 8'(8'h22 + 8'h33 * i);
            pix_b = 8'(8'h33 + 8'h33 * i);
            cyc();
        end
        chk("full_not_ready", pix_ready, 1'b0);
        pix_valid = 1'b0;
        underflow_clr = 1'b1;
        cyc();
        underflow_clr = 1'b0;
        en = 1'b1;
        cyc();
        chk("first_pixel", {dac_r, dac_g, dac_b}, 24'h112233);
        chk("first_frame_start", frame_start, 1'b1);
        run(FT - 1, 0, 1'b0);

        // Continuous streaming: no underflow over a whole frame
        run_to(VA * HT + 1, 100);
        pix_valid = 1'b1;
        underflow_clr = 1'b1;
        cyc();
        underflow_clr = 1'b0;
        pops = 0;
        run(FT, 100, 1'b0);
        chk("stream_pops", pops, HA * VA);
        chk("stream_no_underflow", underflow, 1'b0);

        // Bias shadowing: mid-frame write, then a write at the transfer cycle
        run_to(3 * HT, 60);
        cfg_wr = 1'b1; cfg_bias_r = 3'd1; cfg_bias_gb = 3'd6;
        cyc();
        cfg_wr = 1'b0;
        run_to(VA * HT, 60);
        chk("bias_held", {bias_r, bias_gb}, {BR, BR});
        cfg_wr = 1'b1; cfg_bias_r = 3'd2; cfg_bias_gb = 3'd3;
        cyc();
        cfg_wr = 1'b0;
        chk("bias_applied", {bias_r, bias_gb}, {3'd1, 3'd6});
        run(FT, 60, 1'b0);
        chk("bias_next_frame", {bias_r, bias_gb}, {3'd2, 3'd3});

        // Randomized traffic, config writes and underflow clears
        run(3 * FT, 45, 1'b1);

        // Asynchronous reset mid-line with a partly filled FIFO
        run_to(5 * HT + 4, 30);
        run_to(5 * HT + 9, 100);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_outs();
        chk("pix_ready_after_rst", pix_ready, 1'b1);
        pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("restart_frame_start", frame_start, 1'b1);
        run(FT, 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
